mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/cache_pkg.sv | 14 +
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the cache-side memory arbiter: FSM state encoding
// and requester index constants.
package cache_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_BUSY  = 2'd1,
      ARB_DRAIN = 2'd2
   } arb_state_e;

   localparam logic REQ_DCACHE = 1'b0;
   localparam logic REQ_ICACHE = 1'b1;

endpackage : cache_pkg

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter (m0 = dcache, m1 = icache). A requester holds
// the memory port for as long as its lock is high; ties are broken round
// robin. Reads still in flight when the owner lets go are drained before the
// port can be handed to anyone else.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ARB_IDLE  | no owner; arbitrate between locks, responses are ignored
// ARB_BUSY  | owner's strobes are registered onto the memory port
// ARB_DRAIN | owner released lock, waiting for outstanding reads to return
module mem_arbiter
   import cache_pkg::*;
#(
   parameter int DATABITS = 32,
   parameter int ADDRBITS = 32,
   parameter int OUTBITS  = 4
) (
   input  logic                clk,
   input  logic                reset,

   input  logic                m0_lock,
   input  logic [ADDRBITS-1:0] m0_addr,
   input  logic [DATABITS-1:0] m0_in,
   input  logic                m0_rdreq,
   input  logic                m0_wrreq,
   output logic                m0_grant,
   output logic [DATABITS-1:0] m0_out,
   output logic                m0_out_valid,
   output logic [15:0]         m0_burstlen,

   input  logic                m1_lock,
   input  logic [ADDRBITS-1:0] m1_addr,
   input  logic [DATABITS-1:0] m1_in,
   input  logic                m1_rdreq,
   input  logic                m1_wrreq,
   output logic                m1_grant,
   output logic [DATABITS-1:0] m1_out,
   output logic                m1_out_valid,
   output logic [15:0]         m1_burstlen,

   output logic [ADDRBITS-1:0] mem_addr,
   output logic [DATABITS-1:0] mem_in,
   output logic                mem_rdreq,
   output logic                mem_wrreq,
   input  logic [DATABITS-1:0] mem_out,
   input  logic                mem_out_valid,
   input  logic [15:0]         mem_burstlen
);

   localparam logic [OUTBITS-1:0] OUT_MAX = '1;

   arb_state_e          state;
   logic                owner;
   logic                last_owner;
   logic [OUTBITS-1:0]  outstanding;

   logic                own_lock;
   logic                own_rd;
   logic                own_wr;
   logic [ADDRBITS-1:0] own_addr;
   logic [DATABITS-1:0] own_in;
   logic                pick;
   logic                fwd_rd;
   logic                fwd_wr;
   logic                rsp_take;
   logic [OUTBITS-1:0]  out_next;

   // Select the current owner's request signals and decide what gets forwarded.
   always_comb begin
      own_lock = (owner == REQ_ICACHE) ? m1_lock  : m0_lock;
      own_rd   = (owner == REQ_ICACHE) ? m1_rdreq : m0_rdreq;
      own_wr   = (owner == REQ_ICACHE) ? m1_wrreq : m0_wrreq;
      own_addr = (owner == REQ_ICACHE) ? m1_addr  : m0_addr;
      own_in   = (owner == REQ_ICACHE) ? m1_in    : m0_in;

      // A tie goes to whoever did not own the port last.
      pick     = (m0_lock && m1_lock) ? ~last_owner : m1_lock;

      // A write wins over a simultaneous read; a read that would overflow
      // the outstanding counter is dropped rather than forwarded.
      fwd_wr   = (state == ARB_BUSY) && own_wr;
      fwd_rd   = (state == ARB_BUSY) && own_rd && !own_wr && (outstanding != OUT_MAX);
      rsp_take = mem_out_valid && (state != ARB_IDLE) && (outstanding != '0);

      out_next = outstanding;
      if (fwd_rd && !rsp_take)
         out_next = outstanding + 1'b1;
      else if (!fwd_rd && rsp_take)
         out_next = outstanding - 1'b1;
   end

   // Response routing: data goes to both requesters, the strobe only to the owner.
   always_comb begin
      m0_out       = mem_out;
      m1_out       = mem_out;
      m0_out_valid = mem_out_valid && (state != ARB_IDLE) && (owner == REQ_DCACHE);
      m1_out_valid = mem_out_valid && (state != ARB_IDLE) && (owner == REQ_ICACHE);
      m0_burstlen  = mem_burstlen;
      m1_burstlen  = mem_burstlen;
   end

   // Arbitration FSM, outstanding-read tracking and registered memory port.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ARB_IDLE;
         owner       <= REQ_DCACHE;
         last_owner  <= REQ_ICACHE;
         outstanding <= '0;
         m0_grant    <= 1'b0;
         m1_grant    <= 1'b0;
         mem_rdreq   <= 1'b0;
         mem_wrreq   <= 1'b0;
         mem_addr    <= '0;
         mem_in      <= '0;
      end else begin
         outstanding <= out_next;
         mem_rdreq   <= fwd_rd;
         mem_wrreq   <= fwd_wr;
         if (state == ARB_BUSY) begin
            mem_addr <= own_addr;
            mem_in   <= own_in;
         end

         case (state)
            ARB_IDLE: begin
               if (m0_lock || m1_lock) begin
                  owner    <= pick;
                  state    <= ARB_BUSY;
                  m0_grant <= (pick == REQ_DCACHE);
                  m1_grant <= (pick == REQ_ICACHE);
               end
            end
            ARB_BUSY: begin
               if (!own_lock) begin
                  m0_grant   <= 1'b0;
                  m1_grant   <= 1'b0;
                  last_owner <= owner;
                  state      <= (out_next != '0) ? ARB_DRAIN : ARB_IDLE;
               end
            end
            ARB_DRAIN: begin
               if (out_next == '0)
                  state <= ARB_IDLE;
            end
            default: begin
               state    <= ARB_IDLE;
               m0_grant <= 1'b0;
               m1_grant <= 1'b0;
            end
         endcase
      end
   end

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter, built with OUTBITS=2 so the counter
// saturation case is reachable with a handful of reads.
module tb_mem_arbiter;
   import cache_pkg::*;

   localparam int DATABITS = 32;
   localparam int ADDRBITS = 32;
   localparam int OUTBITS  = 2;

   logic                clk = 1'b0;
   logic                reset;
   logic                m0_lock, m0_rdreq, m0_wrreq, m0_grant, m0_out_valid;
   logic [ADDRBITS-1:0] m0_addr;
   logic [DATABITS-1:0] m0_in, m0_out;
   logic [15:0]         m0_burstlen;
   logic                m1_lock, m1_rdreq, m1_wrreq, m1_grant, m1_out_valid;
   logic [ADDRBITS-1:0] m1_addr;
   logic [DATABITS-1:0] m1_in, m1_out;
   logic [15:0]         m1_burstlen;
   logic [ADDRBITS-1:0] mem_addr;
   logic [DATABITS-1:0] mem_in, mem_out;
   logic                mem_rdreq, mem_wrreq, mem_out_valid;
   logic [15:0]         mem_burstlen;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.DATABITS(DATABITS), .ADDRBITS(ADDRBITS), .OUTBITS(OUTBITS)) dut (
      .clk(clk), .reset(reset),
      .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_in(m0_in), .m0_rdreq(m0_rdreq),
      .m0_wrreq(m0_wrreq), .m0_grant(m0_grant), .m0_out(m0_out),
      .m0_out_valid(m0_out_valid), .m0_burstlen(m0_burstlen),
      .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_in(m1_in), .m1_rdreq(m1_rdreq),
      .m1_wrreq(m1_wrreq), .m1_grant(m1_grant), .m1_out(m1_out),
      .m1_out_valid(m1_out_valid), .m1_burstlen(m1_burstlen),
      .mem_addr(mem_addr), .mem_in(mem_in), .mem_rdreq(mem_rdreq),
      .mem_wrreq(mem_wrreq), .mem_out(mem_out), .mem_out_valid(mem_out_valid),
      .mem_burstlen(mem_burstlen)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      m0_lock = 0; m0_rdreq = 0; m0_wrreq = 0; m0_addr = '0; m0_in = '0;
      m1_lock = 0; m1_rdreq = 0; m1_wrreq = 0; m1_addr = '0; m1_in = '0;
      mem_out = '0; mem_out_valid = 0; mem_burstlen = '0;
      tick(); tick();
      reset = 1'b0;

      // reset state
      chk("rst_m0_grant", m0_grant, 0);
      chk("rst_m1_grant", m1_grant, 0);
      chk("rst_rdreq", mem_rdreq, 0);
      chk("rst_wrreq", mem_wrreq, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_in", mem_in, 0);
      chk("rst_state", dut.state, ARB_IDLE);
      chk("rst_outstanding", dut.outstanding, 0);

      // m0 alone: grant one cycle after lock, four reads each returned
      m0_lock = 1;
      tick();
      chk("t1_m0_grant", m0_grant, 1);
      chk("t1_m1_grant", m1_grant, 0);
      for (int i = 0; i < 4; i++) begin
         m0_addr = 32'h100 + 32'(4 * i);
         m0_rdreq = 1;
         tick();
         chk("t1_rdreq", mem_rdreq, 1);
         chk("t1_addr", mem_addr, 32'h100 + 32'(4 * i));
         m0_rdreq = 0;
         mem_out = 32'hA000_0000 + 32'(i);
         mem_out_valid = 1;
         #1;
         chk("t1_m0_valid", m0_out_valid, 1);
         chk("t1_m1_valid", m1_out_valid, 0);
         chk("t1_m0_out", m0_out, 32'hA000_0000 + 32'(i));
         tick();
         mem_out_valid = 0;
         chk("t1_rd_idle", mem_rdreq, 0);
      end
      chk("t1_outstanding", dut.outstanding, 0);

      // read and write together: only the write goes out
      m0_addr = 32'h200; m0_in = 32'h55; m0_rdreq = 1; m0_wrreq = 1;
      tick();
      chk("rw_wrreq", mem_wrreq, 1);
      chk("rw_rdreq", mem_rdreq, 0);
      chk("rw_in", mem_in, 32'h55);
      m0_rdreq = 0; m0_wrreq = 0;

      // release with nothing outstanding goes straight to idle
      m0_lock = 0;
      tick();
      chk("rel_m0_grant", m0_grant, 0);
      chk("rel_state", dut.state, ARB_IDLE);

      // response in idle is ignored; burst length passes straight through
      mem_out_valid = 1; mem_burstlen = 16'h1234;
      #1;
      chk("idle_m0_valid", m0_out_valid, 0);
      chk("idle_m1_valid", m1_out_valid, 0);
      chk("blen_m0", m0_burstlen, 16'h1234);
      chk("blen_m1", m1_burstlen, 16'h1234);
      mem_out_valid = 0;

      // tie after reset goes to m0; non-owner write is discarded
      reset = 1; tick(); reset = 0;
      m0_lock = 1; m1_lock = 1;
      tick();
      chk("tie_m0_grant", m0_grant, 1);
      chk("tie_m1_grant", m1_grant, 0);
      m1_wrreq = 1; m1_addr = 32'h40; m1_in = 32'hDEADBEEF;
      tick();
      chk("nonowner_wrreq", mem_wrreq, 0);
      m1_wrreq = 0;
      m0_lock = 0;
      tick();
      chk("hand_m0_grant", m0_grant, 0);
      chk("hand_m1_idle", m1_grant, 0);
      tick();
      chk("hand_m1_grant", m1_grant, 1);
      chk("hand_no_queue", mem_wrreq, 0);
      m1_wrreq = 1;
      tick();
      chk("reissue_wrreq", mem_wrreq, 1);
      chk("reissue_in", mem_in, 32'hDEADBEEF);
      chk("reissue_addr", mem_addr, 32'h40);
      m1_wrreq = 0;

      // second tie, last owner m1 -> m0 wins
      m0_lock = 1; m1_lock = 0;
      tick();
      chk("tie2_idle", dut.state, ARB_IDLE);
      m1_lock = 1;
      tick();
      chk("tie2_m0_grant", m0_grant, 1);
      chk("tie2_m1_grant", m1_grant, 0);

      // m1 owns, three reads, drops lock before data; m0 waits for the drain
      m0_lock = 0;
      tick();
      tick();
      chk("t3_m1_grant", m1_grant, 1);
      m0_lock = 1;
      for (int i = 0; i < 3; i++) begin
         m1_addr = 32'h300 + 32'(4 * i);
         m1_rdreq = 1;
         tick();
         chk("t3_rdreq", mem_rdreq, 1);
      end
      m1_rdreq = 0; m1_lock = 0;
      tick();
      chk("t3_state_drain", dut.state, ARB_DRAIN);
      chk("t3_outstanding", dut.outstanding, 3);
      chk("t3_m1_grant_off", m1_grant, 0);
      m1_rdreq = 1;
      tick();
      chk("drain_no_fwd", mem_rdreq, 0);
      m1_rdreq = 0;
      mem_out_valid = 1;
      #1;
      chk("drain_m1_valid", m1_out_valid, 1);
      chk("drain_m0_valid", m0_out_valid, 0);
      tick();
      tick();
      chk("drain_m0_wait", m0_grant, 0);
      tick();
      mem_out_valid = 0;
      chk("drain_done_idle", dut.state, ARB_IDLE);
      chk("drain_m0_notyet", m0_grant, 0);
      tick();
      chk("drain_m0_grant", m0_grant, 1);

      // counter saturation at 3 with OUTBITS=2
      for (int i = 0; i < 4; i++) begin
         m0_addr = 32'h400 + 32'(4 * i);
         m0_rdreq = 1;
         tick();
         chk("sat_rdreq", mem_rdreq, (i < 3) ? 1 : 0);
      end
      m0_rdreq = 0;
      chk("sat_outstanding", dut.outstanding, 3);

      // reset mid-burst with two outstanding
      mem_out_valid = 1;
      tick();
      mem_out_valid = 0;
      chk("pre_rst_outstanding", dut.outstanding, 2);
      reset = 1; m0_lock = 0;
      tick();
      reset = 0;
      chk("mid_rst_m0_grant", m0_grant, 0);
      chk("mid_rst_m1_grant", m1_grant, 0);
      chk("mid_rst_outstanding", dut.outstanding, 0);
      mem_out_valid = 1;
      #1;
      chk("late_m0_valid", m0_out_valid, 0);
      chk("late_m1_valid", m1_out_valid, 0);
      tick();
      mem_out_valid = 0;
      chk("late_outstanding", dut.outstanding, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_mem_arbiter
